// File: rtl/bist_pkg.sv
// bist_pkg: pattern modes, checker states and PRBS-7 constants for loopback_bist
package bist_pkg;
  localparam logic [1:0] MODE_TOGGLE = 2'd0;
  localparam logic [1:0] MODE_COUNT  = 2'd1;
  localparam logic [1:0] MODE_WALK   = 2'd2;
  localparam logic [1:0] MODE_PRBS7  = 2'd3;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HUNT     = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;
  localparam logic [6:0] PRBS_SEED   = 7'h7F;
  localparam int         PRBS_TAP_A  = 6;
  localparam int         PRBS_TAP_B  = 5;
endpackage

// File: rtl/bist_hist_ram.sv
// bist_hist_ram: circular history of i_din (write every i_we cycle), o_dout = value i_lat cycles back, i_lat=0 bypasses to i_din
module bist_hist_ram #(
  parameter int W  = 8,
  parameter int AW = 6
) (
  input  logic          i_clk,
  input  logic          i_res_n,
  input  logic          i_we,
  input  logic [W-1:0]  i_din,
  input  logic [AW-1:0] i_lat,
  output logic [W-1:0]  o_dout
);
  logic [W-1:0]  r_mem [2**AW];
  logic [AW-1:0] r_wp;
  always_ff @(posedge i_clk)
    if (i_we) r_mem[r_wp] <= i_din;
  always_ff @(posedge i_clk or negedge i_res_n)
    if (!i_res_n) r_wp <= '0;
    else if (i_we) r_wp <= r_wp + 1'b1;
  assign o_dout = (i_lat == '0) ? i_din : r_mem[r_wp - i_lat];
endmodule

// File: rtl/loopback_bist.sv
// loopback_bist: divided pattern generator (o_ptn/o_ptn_stb) plus loopback checker on i_rx at latency i_lat (o_locked/o_err/o_err_cnt)
module loopback_bist
  import bist_pkg::*;
#(
  parameter int CH_NUM     = 8,
  parameter int DIV_W      = 16,
  parameter int LAT_W      = 6,
  parameter int ERR_W      = 16,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic              i_clk,
  input  logic              i_res_n,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [LAT_W-1:0]  i_lat,
  input  logic [CH_NUM-1:0] i_rx,
  input  logic              i_err_clr,
  output logic [CH_NUM-1:0] o_ptn,
  output logic              o_ptn_stb,
  output logic              o_locked,
  output logic              o_err,
  output logic [ERR_W-1:0]  o_err_cnt
);
  localparam int CW = $clog2((LOCK_CNT > UNLOCK_CNT ? LOCK_CNT : UNLOCK_CNT) + 1);
  localparam logic [2*CH_NUM-1:0] ALT = {CH_NUM{2'b01}};
  localparam logic [CH_NUM-1:0] P55 = ALT[CH_NUM-1:0];
  logic              r_en_d;
  logic [1:0]        r_mode_d;
  logic [LAT_W-1:0]  r_lat_d;
  logic [DIV_W-1:0]  r_pre;
  logic [6:0]        r_lfsr;
  logic [LAT_W:0]    r_fill;
  logic [CH_NUM-1:0] r_rx, r_exp, w_exp, w_nxt;
  logic              r_vld;
  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt, w_cnt_inc, w_lim;
  logic              w_restart, w_tick, w_fb, w_vld, w_match, w_miss, w_hunt, w_hit, w_drop, w_err;
  bist_hist_ram #(.W(CH_NUM), .AW(LAT_W)) u_hist (
    .i_clk   (i_clk),
    .i_res_n (i_res_n),
    .i_we    (i_en),
    .i_din   (o_ptn),
    .i_lat   (i_lat),
    .o_dout  (w_exp)
  );
  always_comb begin
    w_restart = i_en & (~r_en_d | (i_mode != r_mode_d) | (i_lat != r_lat_d));
    w_tick    = i_en & ~w_restart & (r_pre == i_div);
    w_fb      = r_lfsr[PRBS_TAP_A] ^ r_lfsr[PRBS_TAP_B];
    w_nxt     = (i_mode == MODE_TOGGLE) ? ((o_ptn == P55) ? ~P55 : P55) :
                (i_mode == MODE_COUNT)  ? o_ptn + 1'b1 :
                (i_mode == MODE_WALK)   ? ((o_ptn == '0) ? CH_NUM'(1) : {o_ptn[CH_NUM-2:0], o_ptn[CH_NUM-1]}) :
                                          {o_ptn[CH_NUM-2:0], w_fb};
    w_vld     = i_en & ~w_restart & (r_fill >= {1'b0, i_lat});
    w_match   = r_vld & (r_rx == r_exp);
    w_miss    = r_vld & (r_rx != r_exp);
    w_hunt    = r_state == ST_HUNT;
    w_hit     = w_hunt ? w_match : w_miss;
    w_drop    = w_hunt ? w_miss : w_match;
    w_lim     = w_hunt ? CW'(LOCK_CNT) : CW'(UNLOCK_CNT);
    w_cnt_inc = r_cnt + 1'b1;
    w_err     = i_en & ~w_restart & (r_state == ST_LOCKED) & w_miss;
  end
  always_ff @(posedge i_clk or negedge i_res_n)
    if (!i_res_n) begin
      r_en_d    <= 1'b0;
      r_mode_d  <= '0;
      r_lat_d   <= '0;
      r_pre     <= '0;
      r_lfsr    <= PRBS_SEED;
      r_fill    <= '0;
      o_ptn     <= '0;
      o_ptn_stb <= 1'b0;
      r_rx      <= '0;
      r_exp     <= '0;
      r_vld     <= 1'b0;
    end else begin
      r_en_d    <= i_en;
      r_mode_d  <= i_mode;
      r_lat_d   <= i_lat;
      r_pre     <= (!i_en || w_restart || w_tick) ? '0 : r_pre + 1'b1;
      r_lfsr    <= (!i_en || w_restart) ? PRBS_SEED : (w_tick && i_mode == MODE_PRBS7) ? {r_lfsr[5:0], w_fb} : r_lfsr;
      r_fill    <= (!i_en || w_restart) ? '0 : (&r_fill) ? r_fill : r_fill + 1'b1;
      o_ptn     <= (!i_en || w_restart) ? '0 : w_tick ? w_nxt : o_ptn;
      o_ptn_stb <= w_tick;
      r_rx      <= i_rx;
      r_exp     <= w_exp;
      r_vld     <= w_vld;
    end
  always_ff @(posedge i_clk or negedge i_res_n)
    if (!i_res_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (!i_en) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (w_restart || r_state == ST_IDLE) begin
      r_state <= ST_HUNT;
      r_cnt   <= '0;
    end else if (w_drop) begin
      r_cnt   <= '0;
    end else if (w_hit) begin
      r_cnt   <= (w_cnt_inc == w_lim) ? '0 : w_cnt_inc;
      if (w_cnt_inc == w_lim) r_state <= w_hunt ? ST_LOCKED : ST_HUNT;
    end
  always_ff @(posedge i_clk or negedge i_res_n)
    if (!i_res_n) begin
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      o_err     <= w_err;
      o_err_cnt <= i_err_clr ? '0 : (w_err && o_err_cnt != '1) ? o_err_cnt + 1'b1 : o_err_cnt;
    end
  assign o_locked = r_state == ST_LOCKED;
endmodule

// File: tb/tb_loopback_bist.sv
// tb_loopback_bist: randomized loopback stimulus checked against a per-cycle behavioural model of loopback_bist
module tb_loopback_bist;
  localparam int CH = 8;
  localparam int LOCK_CNT = 16;
  localparam int UNLOCK_CNT = 4;
  localparam int ERR_MAX = 15;
  logic          i_clk, i_res_n, i_en, i_err_clr;
  logic [1:0]    i_mode;
  logic [15:0]   i_div;
  logic [5:0]    i_lat;
  logic [CH-1:0] i_rx;
  logic [CH-1:0] o_ptn;
  logic          o_ptn_stb, o_locked, o_err;
  logic [3:0]    o_err_cnt;
  int            n_vec, n_err;
  bit            prbs [0:4095];
  logic [CH-1:0] hist [0:4095];
  int            cmp  [0:4095];
  logic [CH-1:0] flip [0:4095];
  bit            clr  [0:4095];
  bit            m_locked, m_err;
  int            m_run, m_cnt;
  loopback_bist #(.CH_NUM(CH), .ERR_W(4), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
    .i_clk     (i_clk),
    .i_res_n   (i_res_n),
    .i_en      (i_en),
    .i_mode    (i_mode),
    .i_div     (i_div),
    .i_lat     (i_lat),
    .i_rx      (i_rx),
    .i_err_clr (i_err_clr),
    .o_ptn     (o_ptn),
    .o_ptn_stb (o_ptn_stb),
    .o_locked  (o_locked),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic step;
    @(posedge i_clk);
    #1;
  endtask
  function automatic logic [CH-1:0] pat(input int mode, input int k);
    logic [CH-1:0] p = '0;
    if (k == 0) return '0;
    case (mode)
      0: for (int i = 0; i < CH; i++) p[i] = ((i % 2) == 0) == ((k % 2) == 1);
      1: p = CH'(k);
      2: p[(k - 1) % CH] = 1'b1;
      default: for (int i = 0; i < CH; i++) if (k - 1 - i >= 0) p[i] = prbs[k - 1 - i];
    endcase
    return p;
  endfunction
  task automatic model_step(input int t);
    m_err = 1'b0;
    if (t >= 2 && cmp[t-2] != 0) begin
      if (!m_locked) begin
        if (cmp[t-2] == 1) begin
          m_run++;
          if (m_run == LOCK_CNT) begin m_locked = 1'b1; m_run = 0; end
        end else m_run = 0;
      end else begin
        if (cmp[t-2] == 2) begin
          m_err = 1'b1;
          m_run++;
          if (m_run == UNLOCK_CNT) begin m_locked = 1'b0; m_run = 0; end
        end else m_run = 0;
      end
    end
    if (t >= 1) m_cnt = clr[t-1] ? 0 : (m_err && m_cnt < ERR_MAX) ? m_cnt + 1 : m_cnt;
  endtask
  task automatic clear_stim;
    for (int t = 0; t < 4096; t++) begin flip[t] = '0; clr[t] = 1'b0; end
  endtask
  task automatic run(input int mode, input int div, input int lat, input int dly, input int n, input bit via_en);
    logic [CH-1:0] rx;
    if (via_en || (2'(mode) == i_mode && 6'(lat) == i_lat)) begin
      i_en = 1'b0;
      step;
      check("idle_ptn", o_ptn, 0);
      check("idle_stb", o_ptn_stb, 0);
      check("idle_locked", o_locked, 0);
      check("idle_err", o_err, 0);
      check("idle_err_cnt", o_err_cnt, m_cnt);
    end
    i_mode = 2'(mode);
    i_div = 16'(div);
    i_lat = 6'(lat);
    i_en = 1'b1;
    step;
    m_locked = 1'b0;
    m_run = 0;
    for (int t = 0; t < n; t++) begin
      hist[t] = pat(mode, t / (div + 1));
      model_step(t);
      check("ptn", o_ptn, hist[t]);
      check("stb", o_ptn_stb, 32'(t > 0 && t % (div + 1) == 0));
      check("locked", o_locked, m_locked);
      check("err", o_err, m_err);
      check("err_cnt", o_err_cnt, m_cnt);
      rx = ((t >= dly) ? hist[t - dly] : '0) ^ flip[t];
      i_rx = rx;
      i_err_clr = clr[t];
      cmp[t] = (t >= lat) ? ((rx == hist[t - lat]) ? 1 : 2) : 0;
      step;
    end
    i_rx = '0;
    i_err_clr = 1'b0;
    model_step(n);
  endtask
  initial begin
    bit a, b;
    int lat, dly, n;
    n_vec = 0;
    n_err = 0;
    for (int k = 0; k < 4096; k++) begin
      a = (k >= 7) ? prbs[k - 7] : 1'b1;
      b = (k >= 6) ? prbs[k - 6] : 1'b1;
      prbs[k] = a ^ b;
    end
    i_res_n = 1'b0;
    i_en = 1'b0;
    i_mode = '0;
    i_div = '0;
    i_lat = '0;
    i_rx = '0;
    i_err_clr = 1'b0;
    m_cnt = 0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ptn", o_ptn, 0);
    check("rst_stb", o_ptn_stb, 0);
    check("rst_locked", o_locked, 0);
    check("rst_err", o_err, 0);
    check("rst_err_cnt", o_err_cnt, 0);
    i_res_n = 1'b1;
    step;
    clear_stim(); run(1, 0, 3, 3, 300, 1);
    clear_stim(); run(1, 0, 2, 3, 200, 1);
    clear_stim();
    flip[100] = 8'h01;
    for (int j = 0; j < 4; j++) flip[150 + j] = 8'h01;
    run(1, 0, 3, 3, 260, 1);
    clear_stim(); run(3, 2, 0, 0, 900, 0);
    clear_stim();
    lat = $urandom_range(0, 20);
    run(0, $urandom_range(0, 3), lat, lat, 200, 0);
    clear_stim(); run(2, 0, 5, 5, 100, 0);
    clear_stim();
    for (int j = 0; j < 10; j++) for (int i = 0; i < 3; i++) flip[40 + 30 * j + i] = 8'h80;
    clr[40 + 30 * 9 + 1] = 1'b1;
    run(1, 0, 3, 3, 400, 1);
    #3 i_res_n = 1'b0;
    #1;
    check("arst_ptn", o_ptn, 0);
    check("arst_stb", o_ptn_stb, 0);
    check("arst_locked", o_locked, 0);
    check("arst_err", o_err, 0);
    check("arst_err_cnt", o_err_cnt, 0);
    step;
    i_res_n = 1'b1;
    m_cnt = 0;
    for (int r = 0; r < 15; r++) begin
      clear_stim();
      lat = $urandom_range(0, 63);
      dly = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : lat;
      n = lat + 150 + $urandom_range(0, 100);
      for (int t = 0; t < n; t++) begin
        if ($urandom_range(0, 39) == 0) flip[t] = 8'($urandom_range(1, 255));
        if ($urandom_range(0, 59) == 0) clr[t] = 1'b1;
      end
      run($urandom_range(0, 3), $urandom_range(0, 4), lat, dly, n, 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/loopback_bist.md
Name: loopback_bist

Overview:
- Parametrised built-in self-test block for the SFP transceiver link.
- The generator drives a CH_NUM-bit test pattern, clock-enabled by a programmable divider, toward the TTL/LVDS path.
- The checker compares the looped-back word against the generated history at a programmable latency, then reports lock and error statistics.
- It replaces the fixed, testbench-only dummy pattern source with a synthesizable, multi-mode generator and checker usable on hardware.

Parameters:
CH_NUM, 8, pattern/channel width (2..32)
DIV_W, 16, divider width
LAT_W, 6, latency index width; history depth = 2**LAT_W
ERR_W, 16, error counter width
LOCK_CNT, 16, consecutive matches needed to lock
UNLOCK_CNT, 4, consecutive mismatches that drop lock

Ports:
i_clk  in  1  system clock (60 MHz)
i_res_n  in  1  asynchronous active-low reset
i_en  in  1  enable generator and checker
i_mode  in  2  0=toggle 0x55../0xAA.., 1=binary counter, 2=walking one, 3=PRBS-7 window
i_div  in  DIV_W  tick every i_div+1 cycles
i_lat  in  LAT_W  expected loop latency in clocks
i_rx  in  CH_NUM  looped-back word, already synchronous to i_clk
i_err_clr  in  1  clear error counter (pulse)
o_ptn  out  CH_NUM  generated pattern (registered)
o_ptn_stb  out  1  one-cycle pulse when o_ptn updates
o_locked  out  1  checker in LOCKED
o_err  out  1  one-cycle pulse per mismatch while LOCKED
o_err_cnt  out  ERR_W  saturating mismatch count

Behaviour:
- Reset: o_ptn=0, o_ptn_stb=0, o_locked=0, o_err=0, o_err_cnt=0, state IDLE, LFSR=7'h7F, prescaler=0, history write pointer=0.
- Asynchronous reset is legal mid-operation; all state returns to reset values immediately.
- Prescaler:
  - Counts 0..i_div while i_en=1; tick when count==i_div, then wraps to 0. i_div=0 gives a tick every cycle.
  - On each tick, o_ptn advances in the following cycle and o_ptn_stb pulses in that same cycle.
- Patterns (CH_NUM bits; first tick after restart produces the first value):
  - mode0: alternates {..0101}, {..1010}, starting with {..0101}.
  - mode1: 1, 2, 3, …; wraps from all-ones to 0.
  - mode2: 1, 2, 4, …, MSB, then back to 1.
  - mode3: LFSR x^7+x^6+1, fb=lfsr[6]^lfsr[5], lfsr<={lfsr[5:0],fb}; o_ptn<={o_ptn[CH_NUM-2:0],fb}. Period 127 ticks.
- Restart (prescaler=0, o_ptn=0, LFSR=7F, checker to HUNT with counters cleared) on any of:
  - i_en rising
  - i_mode change
  - i_lat change
- i_en=0: state IDLE, o_ptn forced 0, no strobes, o_locked=0. o_err_cnt is held.
- History buffer: 2**LAT_W × CH_NUM circular buffer, written with o_ptn every enabled cycle. The pointer wraps modulo depth.
  - exp = o_ptn value from i_lat cycles earlier (i_lat=0 means the current o_ptn).
  - Compare registered i_rx against exp; result is valid one cycle later.
  - Comparisons are masked until i_lat+1 writes have occurred since restart (fill counter saturates).
- Checker FSM:
  - IDLE -> HUNT when i_en=1.
  - HUNT: a match increments the match count; a mismatch clears it. Reaching LOCK_CNT -> LOCKED, with o_locked=1 the same cycle the state register changes.
  - LOCKED: a mismatch pulses o_err, increments o_err_cnt (saturating at all-ones), and increments the miss count. A match clears the miss count. UNLOCK_CNT consecutive misses -> HUNT (o_locked=0).
  - Any state -> IDLE when i_en=0.
- o_err_cnt:
  - i_err_clr has priority; a simultaneous error leaves the count at 0.
  - Not cleared by restart; cleared only by i_err_clr or reset.
- Masked comparisons are neither matches nor mismatches.

Decomposition:
- Package bist_pkg: mode encodings (MODE_TOGGLE/COUNT/WALK/PRBS7), FSM state encodings (IDLE/HUNT/LOCKED), PRBS seed 7'h7F, tap positions.
- One sub-module: bist_hist_ram (circular history buffer with write pointer and read at offset i_lat). It must be inferable as distributed RAM or registers.
- Generator, prescaler and FSM stay in the top module.

Test Plan:
- mode1, i_div=0, i_rx = o_ptn delayed 3 clocks, i_lat=3 -> o_locked=1 after fill (4 cycles) + 16 matches + 1; o_err_cnt stays 0 for 1000 cycles.
- Same stimulus with i_lat=2 -> o_locked never asserts, o_err never pulses.
- Locked case, one bit of i_rx inverted for 1 cycle -> single o_err pulse, o_err_cnt=1, still locked. Inverting 4 consecutive cycles -> o_locked drops, o_err_cnt=5.
- mode3, i_div=2, CH_NUM=8 -> o_ptn_stb every 3rd cycle; o_ptn=0x00 for 6 ticks, 0x01 on tick 7; sequence repeats after 127 ticks.
- mode2, CH_NUM=8, i_div=0 -> 0x01, 0x02, …, 0x80, 0x01. Changing i_mode mid-run -> o_ptn=0, o_locked=0 next cycle, restart from first value.
- ERR_W=4 with persistent errors -> o_err_cnt saturates at 15. i_err_clr coincident with error -> 0. i_res_n low mid-run -> all outputs 0 asynchronously.
